apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB4 initiator: converts a single-outstanding request/response port (CPU-side, e.g. ahb_ibus
//  peripheral path) into APB setup/access transfers toward APB responders such as SRAM bridges.
//  Handles PREADY wait states, PSLVERR, and a wait-state timeout that aborts hung transfers.
// PARAMETERS
//  AW      32  address width of cmd_addr/paddr
//  TO_CYC  256 max ACCESS cycles with pready=0 before abort; 0 disables timeout
// PORTS
//  pclk       in   1   clock
//  preset_n   in   1   async active-low reset
//  cmd_req    in   1   request valid
//  cmd_gnt    out  1   request accepted when cmd_req&cmd_gnt at pclk rise
//  cmd_we     in   1   1=write, 0=read
//  cmd_addr   in   AW  byte address
//  cmd_strb   in   4   write byte strobes
//  cmd_wdata  in   32  write data
//  rsp_vld    out  1   one-cycle response pulse
//  rsp_rdata  out  32  read data (0 for writes/errors)
//  rsp_err    out  1   pslverr or timeout, valid with rsp_vld
//  psel       out  1   APB select
//  penable    out  1   APB enable
//  paddr      out  AW  APB address
//  pwrite     out  1   APB direction
//  pstrb      out  4   APB strobes (forced 0 on reads)
//  pwdata     out  32  APB write data
//  prdata     in   32  APB read data
//  pready     in   1   APB ready
//  pslverr    in   1   APB error, sampled only when penable&pready
// BEHAVIOUR
//  - One clock pclk; reset async active-low preset_n. All outputs reset to 0; state=IDLE, timer=0.
//  - FSM IDLE->SETUP->ACCESS->IDLE. cmd_gnt = (state==IDLE), combinational from state only.
//  - IDLE: cmd_req -> latch we/addr/strb/wdata into paddr/pwrite/pstrb/pwdata; go SETUP.
//  - SETUP: psel=1, penable=0; unconditionally go ACCESS next cycle.
//  - ACCESS: psel=1, penable=1; paddr/pwrite/pstrb/pwdata stable from SETUP until exit.
//    pready=1 -> rsp_vld=1 next cycle, rsp_err=pslverr, rsp_rdata=(~pwrite&~pslverr)?prdata:0; go IDLE.
//    pready=0 -> stay; timer++ (saturating, $clog2(TO_CYC+1) bits).
//  - Timeout: TO_CYC!=0 and timer==TO_CYC-1 with pready=0 -> abort: psel/penable drop next
//    cycle, rsp_vld=1, rsp_err=1, rsp_rdata=0; go IDLE. Late pready after abort ignored.
//  - Latency: accept at edge k; SETUP k+1; ACCESS k+2; pready=1 at k+2 -> rsp_vld at k+3,
//    cmd_gnt high again at k+3. Min 3 cycles/transfer; no pipelining of next SETUP.
//  - pstrb = cmd_strb on writes, 4'b0000 on reads. pwdata=0 on reads.
//  - Outside transfers paddr/pwrite/pwdata hold last value (no toggling); psel=penable=0.
//  - rsp_vld exactly one cycle per accepted cmd; never without a prior grant.
//  - Reset mid-transfer: psel/penable/rsp_vld to 0 immediately; in-flight transfer lost, no rsp.
//  - cmd_req while not IDLE: ignored (cmd_gnt=0); requester must hold until granted.
// STRUCTURE
//  - Shared pkg apb_pkg: state enum {IDLE=2'b00,SETUP=2'b01,ACCESS=2'b10}, APB_DW=32, APB_SW=4.
//  - Sub-module apb_wait_timer: clear/enable/expire counter parameterised by TO_CYC.
//  - Top: FSM, request capture regs, response regs; all outputs registered except cmd_gnt.
// TESTING
//  - Read 0x0000_0010, pready=1 in ACCESS, prdata=0xDEADBEEF -> psel k+1..k+2, penable k+2,
//    rsp_vld k+3, rsp_rdata=0xDEADBEEF, rsp_err=0, pstrb=0.
//  - Write 0x20, wdata 0x12345678, strb 4'b0011, 2 wait states -> ACCESS 3 cycles, signals
//    stable, pstrb=4'b0011, rsp_vld once, rsp_err=0.
//  - Read with pready=1,pslverr=1, prdata=0xFFFF_FFFF -> rsp_err=1, rsp_rdata=0.
//  - TO_CYC=8, pready held 0 -> exactly 8 ACCESS cycles, psel drops, rsp_err=1, rsp_rdata=0;
//    later pready=1 -> no extra rsp_vld.
//  - preset_n low during ACCESS -> all outputs 0 asynchronously; after release cmd_gnt=1, no rsp.
//  - cmd_req held high for 4 cmds, pready=1 -> grants every 3rd cycle, 4 rsp_vld in order,
//    addresses match; TO_CYC=0 with 300 wait states -> no timeout.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the bridge FSM state encoding.
package apb_pkg;

  localparam int unsigned APB_DW = 32;
  localparam int unsigned APB_SW = 4;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t IDLE   = 2'b00;
  localparam apb_state_t SETUP  = 2'b01;
  localparam apb_state_t ACCESS = 2'b10;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expire flags the last allowed ACCESS wait cycle.
module apb_wait_timer #(
  parameter int unsigned TO_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned TW = (TO_CYC == 0) ? 1 : $clog2(TO_CYC + 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // TO_CYC == 0 disables the abort entirely.
  assign expire = (TO_CYC != 0) && (count_q == TW'(TO_CYC - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 initiator: one outstanding request mapped onto SETUP/ACCESS with wait-state timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned TO_CYC = 256
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_req,
  output logic              cmd_gnt,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [APB_SW-1:0] cmd_strb,
  input  logic [APB_DW-1:0] cmd_wdata,
  output logic              rsp_vld,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic [AW-1:0]     paddr,
  output logic              pwrite,
  output logic [APB_SW-1:0] pstrb,
  output logic [APB_DW-1:0] pwdata,
  input  logic [APB_DW-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t          state_q, state_d;
  logic                psel_d, penable_d, pwrite_d;
  logic [AW-1:0]       paddr_d;
  logic [APB_SW-1:0]   pstrb_d;
  logic [APB_DW-1:0]   pwdata_d, rsp_rdata_d;
  logic                rsp_vld_d, rsp_err_d;
  logic                timer_expire;

  apb_wait_timer #(
    .TO_CYC (TO_CYC)
  ) u_wait_timer (
    .clk    (pclk),
    .rst_n  (preset_n),
    .clear  (state_q != ACCESS),
    .enable ((state_q == ACCESS) && !pready),
    .expire (timer_expire)
  );

  assign cmd_gnt = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel;
    penable_d   = penable;
    paddr_d     = paddr;
    pwrite_d    = pwrite;
    pstrb_d     = pstrb;
    pwdata_d    = pwdata;
    rsp_vld_d   = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    case (state_q)
      IDLE: begin
        if (cmd_req) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_we;
          pstrb_d   = cmd_we ? cmd_strb : '0;
          pwdata_d  = cmd_we ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_vld_d   = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = (!pwrite && !pslverr) ? prdata : '0;
        end else if (timer_expire) begin
          // Hung responder: abort and report an error; a late pready lands in IDLE.
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_vld_d   = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pstrb     <= '0;
      pwdata    <= '0;
      rsp_vld   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      psel      <= psel_d;
      penable   <= penable_d;
      paddr     <= paddr_d;
      pwrite    <= pwrite_d;
      pstrb     <= pstrb_d;
      pwdata    <= pwdata_d;
      rsp_vld   <= rsp_vld_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: TO_CYC=8 and TO_CYC=0 instances share all inputs.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        cmd_req, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata, prdata;
  logic [3:0]  cmd_strb;
  logic        pready, pslverr;

  logic        gnt_a, rsp_vld_a, rsp_err_a, psel_a, penable_a, pwrite_a;
  logic [31:0] rsp_rdata_a, paddr_a, pwdata_a;
  logic [3:0]  pstrb_a;
  logic        gnt_b, rsp_vld_b, rsp_err_b, psel_b, penable_b, pwrite_b;
  logic [31:0] rsp_rdata_b, paddr_b, pwdata_b;
  logic [3:0]  pstrb_b;

  int checks = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.AW(32), .TO_CYC(8)) u_dut_a (
    .pclk(pclk), .preset_n(preset_n), .cmd_req(cmd_req), .cmd_gnt(gnt_a), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_strb(cmd_strb), .cmd_wdata(cmd_wdata), .rsp_vld(rsp_vld_a),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .psel(psel_a), .penable(penable_a),
    .paddr(paddr_a), .pwrite(pwrite_a), .pstrb(pstrb_a), .pwdata(pwdata_a), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  apb_master_bridge #(.AW(32), .TO_CYC(0)) u_dut_b (
    .pclk(pclk), .preset_n(preset_n), .cmd_req(cmd_req), .cmd_gnt(gnt_b), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_strb(cmd_strb), .cmd_wdata(cmd_wdata), .rsp_vld(rsp_vld_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .psel(psel_b), .penable(penable_b),
    .paddr(paddr_b), .pwrite(pwrite_b), .pstrb(pstrb_b), .pwdata(pwdata_b), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rd;
    logic        err;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] model_mem[8];
  logic [31:0] apb_mem[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One transfer with waits < 8; entered and left at #1 after a rising edge in IDLE.
  task automatic run_xfer(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata, input int waits, input logic [31:0] rd,
                          input logic err, input logic exp_err, input logic [31:0] exp_rdata,
                          output logic [31:0] o_pwdata, output logic [3:0] o_pstrb);
    logic [31:0] exp_pwdata;
    logic [3:0]  exp_pstrb;
    int          n;
    logic        done;
    exp_pwdata = we ? wdata : 32'h0;
    exp_pstrb  = we ? strb : 4'h0;
    chk("gnt_idle", 32'(gnt_a), 32'd1);
    cmd_req = 1'b1; cmd_we = we; cmd_addr = addr; cmd_strb = strb; cmd_wdata = wdata;
    @(posedge pclk); #1;
    cmd_req = 1'b0; cmd_we = ~we; cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_strb = 4'($urandom);
    chk("setup_psel", 32'(psel_a), 32'd1);
    chk("setup_penable", 32'(penable_a), 32'd0);
    chk("setup_gnt", 32'(gnt_a), 32'd0);
    chk("setup_paddr", paddr_a, addr);
    chk("setup_pwrite", 32'(pwrite_a), 32'(we));
    chk("setup_pstrb", 32'(pstrb_a), 32'(exp_pstrb));
    chk("setup_pwdata", pwdata_a, exp_pwdata);
    o_pwdata = pwdata_a;
    o_pstrb  = pstrb_a;
    @(posedge pclk); #1;
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      chk("access_phase", {30'd0, psel_a, penable_a}, 32'd3);
      chk("access_paddr", paddr_a, addr);
      chk("access_pwdata", pwdata_a, exp_pwdata);
      chk("access_pstrb", 32'(pstrb_a), 32'(exp_pstrb));
      if (n == waits) begin
        pready = 1'b1; pslverr = err; prdata = rd;
      end else begin
        pready = 1'b0; pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
      end
      @(posedge pclk); #1;
      n++;
      if (rsp_vld_a) done = 1'b1;
    end
    pready = 1'b0; pslverr = 1'b0;
    chk("access_cycles", 32'(n), 32'(waits + 1));
    chk("rsp_vld_a", 32'(rsp_vld_a), 32'd1);
    chk("rsp_err_a", 32'(rsp_err_a), 32'(exp_err));
    chk("rsp_rdata_a", rsp_rdata_a, exp_rdata);
    chk("rsp_vld_b", 32'(rsp_vld_b), 32'd1);
    chk("rsp_err_b", 32'(rsp_err_b), 32'(exp_err));
    chk("rsp_rdata_b", rsp_rdata_b, exp_rdata);
    chk("done_psel_penable", {30'd0, psel_a, penable_a}, 32'd0);
    chk("done_gnt", 32'(gnt_a), 32'd1);
    @(posedge pclk); #1;
    chk("rsp_one_pulse", {30'd0, rsp_vld_a, rsp_vld_b}, 32'd0);
    chk("paddr_hold", paddr_a, addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pw, tmp, addrs[4], exp_rd, rd;
    logic [3:0]  ps, strb;
    logic        we, err;
    int          idx, acc_a, vld_a, vld_b, issued, nrsp;
    int          gcyc[$];
    logic [31:0] seen[$];
    logic        granted;

    vecs[0] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0055, 0, 32'hDEAD_BEEF, 1'b0, 1'b0,
                32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0020, 4'b0011, 32'h1234_5678, 2, 32'hAAAA_5555, 1'b0, 1'b0,
                32'h0};
    vecs[2] = '{1'b0, 32'h0000_0030, 4'h0, 32'h0, 0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0040, 4'b1000, 32'hCAFE_0001, 1, 32'h1111_2222, 1'b1, 1'b1,
                32'h0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, 7, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D};
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = 32'h0;
      apb_mem[i]   = 32'h0;
    end

    preset_n = 1'b0; cmd_req = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_strb = 4'h0;
    cmd_wdata = 32'h0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_apb", {28'd0, psel_a, penable_a, pwrite_a, rsp_vld_a}, 32'd0);
    chk("reset_paddr", paddr_a, 32'h0);
    chk("reset_pwdata", pwdata_a, 32'h0);
    chk("reset_pstrb", 32'(pstrb_a), 32'h0);
    chk("reset_rsp", {31'd0, rsp_err_a} | rsp_rdata_a, 32'h0);
    chk("reset_gnt", 32'(gnt_a), 32'd1);
    @(negedge pclk) preset_n = 1'b1;
    @(posedge pclk); #1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].we, vecs[i].addr, vecs[i].strb, vecs[i].wdata, vecs[i].waits, vecs[i].rd,
               vecs[i].err, vecs[i].exp_err, vecs[i].exp_rdata, pw, ps);
    end

    // Random traffic against a word memory model; the responder keeps its own copy
    // written only from what appears on the APB pins.
    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom_range(0, 1));
      idx  = int'($urandom_range(0, 7));
      tmp  = $urandom;
      rd   = 32'(idx);
      cmd_addr = {tmp[31:5], rd[2:0], 2'b00};
      err  = ($urandom_range(0, 7) == 0);
      strb = 4'($urandom);
      tmp  = $urandom;
      exp_rd = (!we && !err) ? model_mem[idx] : 32'h0;
      rd   = we ? $urandom : apb_mem[idx];
      run_xfer(we, cmd_addr, strb, tmp, int'($urandom_range(0, 4)), rd, err, err, exp_rd,
               pw, ps);
      if (we && !err) begin
        model_mem[idx] = merge(model_mem[idx], tmp, strb);
        apb_mem[idx]   = merge(apb_mem[idx], pw, ps);
      end
    end

    // Timeout on TO_CYC=8 while the TO_CYC=0 instance keeps waiting 300 cycles
    cmd_req = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h50; pready = 1'b0;
    @(posedge pclk); #1;
    cmd_req = 1'b0;
    @(posedge pclk); #1;
    acc_a = 0; vld_a = 0; vld_b = 0;
    for (int c = 0; c < 300; c++) begin
      if (psel_a && penable_a) acc_a++;
      if (rsp_vld_a) begin
        vld_a++;
        chk("timeout_err", 32'(rsp_err_a), 32'd1);
        chk("timeout_rdata", rsp_rdata_a, 32'h0);
      end
      if (rsp_vld_b) vld_b++;
      @(posedge pclk); #1;
    end
    chk("timeout_access_cycles", 32'(acc_a), 32'd8);
    chk("timeout_rsp_count", 32'(vld_a), 32'd1);
    chk("timeout_psel_dropped", 32'(psel_a), 32'd0);
    chk("noto_no_rsp", 32'(vld_b), 32'd0);
    chk("noto_still_access", {30'd0, psel_b, penable_b}, 32'd3);
    pready = 1'b1; prdata = 32'h1357_9BDF;
    @(posedge pclk); #1;
    pready = 1'b0;
    chk("late_pready_ignored", 32'(rsp_vld_a), 32'd0);
    chk("noto_rsp_vld", 32'(rsp_vld_b), 32'd1);
    chk("noto_rsp_rdata", rsp_rdata_b, 32'h1357_9BDF);
    chk("noto_rsp_err", 32'(rsp_err_b), 32'd0);
    @(posedge pclk); #1;

    // Asynchronous reset during ACCESS
    cmd_req = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h60; cmd_strb = 4'hF; cmd_wdata = 32'h5A5A_5A5A;
    @(posedge pclk); #1;
    cmd_req = 1'b0;
    @(posedge pclk); #1;
    chk("pre_reset_access", {30'd0, psel_a, penable_a}, 32'd3);
    #2 preset_n = 1'b0;
    #1;
    chk("async_rst_apb", {28'd0, psel_a, penable_a, pwrite_a, rsp_vld_a}, 32'd0);
    chk("async_rst_bus", paddr_a | pwdata_a | 32'(pstrb_a), 32'h0);
    chk("async_rst_b", {29'd0, psel_b, penable_b, rsp_vld_b}, 32'd0);
    @(negedge pclk) preset_n = 1'b1;
    pready = 1'b1;
    vld_a = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge pclk); #1;
      if (rsp_vld_a || psel_a) vld_a++;
    end
    pready = 1'b0;
    chk("post_reset_quiet", 32'(vld_a), 32'd0);
    chk("post_reset_gnt", 32'(gnt_a), 32'd1);

    // Back-to-back requests with cmd_req held high
    addrs[0] = 32'h100; addrs[1] = 32'h204; addrs[2] = 32'h308; addrs[3] = 32'h40C;
    pready = 1'b1; pslverr = 1'b0; cmd_we = 1'b0; cmd_req = 1'b1; cmd_addr = addrs[0];
    issued = 0; nrsp = 0;
    for (int c = 0; c < 20; c++) begin
      prdata = paddr_a ^ 32'hA5A5_A5A5;
      if (psel_a && penable_a) seen.push_back(paddr_a);
      if (rsp_vld_a) begin
        if (nrsp < 4) chk("b2b_rdata_order", rsp_rdata_a, addrs[nrsp] ^ 32'hA5A5_A5A5);
        nrsp++;
      end
      granted = cmd_req && gnt_a;
      if (granted) gcyc.push_back(c);
      @(posedge pclk); #1;
      if (granted) begin
        issued++;
        if (issued == 4) cmd_req = 1'b0;
        else cmd_addr = addrs[issued];
      end
    end
    pready = 1'b0;
    chk("b2b_grants", 32'(gcyc.size()), 32'd4);
    chk("b2b_rsp_count", 32'(nrsp), 32'd4);
    chk("b2b_access_count", 32'(seen.size()), 32'd4);
    for (int i = 1; i < gcyc.size(); i++) chk("b2b_grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    for (int i = 0; i < seen.size() && i < 4; i++) chk("b2b_paddr", seen[i], addrs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
